// File: rtl/imul_pkg.sv
// Shared definitions for the integer-multiplier readout path: FSM encoding,
// default operand width and the BCD digit-count sufficiency check.
package imul_pkg;

    localparam int DEFAULT_SIZE = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // True when 10^digits exceeds the largest pw-bit unsigned value.
    function automatic bit digits_sufficient(input int digits, input int pw);
        longint unsigned lim;
        longint unsigned maxv;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        maxv = (64'd1 << pw) - 64'd1;
        return lim > maxv;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/imul_product_bcd_converter.sv
// Iterative binary-to-BCD converter for the multiplier product, one bit per clock.
// Optional IMUL_BCD_SIGNED_EN treats the product as two's complement (magnitude + oSign).
module imul_product_bcd_converter
    import imul_pkg::*;
#(
    parameter int SIZE   = DEFAULT_SIZE,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    input  logic [2*SIZE-1:0]     iProduct,
    output logic                  oReady,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [4*DIGITS-1:0]   oBcd,
    output logic                  oSign,
    output logic                  oBusy
);

    localparam int PW = 2 * SIZE;
    localparam int BW = 4 * DIGITS;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    if (!digits_sufficient(DIGITS, PW)) begin : g_digits_check
        $error("DIGITS too small to hold every PW-bit product");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] bin;
    logic [BW-1:0] bcd;
    logic [BW-1:0] bcd_adj;
    logic [BW-1:0] bcd_nxt;
    logic [PW-1:0] load_val;
    logic          accept;
    logic          last;
    logic          unused_top;

    assign accept = (state == IDLE) && iValid;
    assign last   = (cnt == CNT_LAST);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .din  (bcd[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // The top digit never reaches 5, so its corrected MSB is shifted out unused.
    assign bcd_nxt    = {bcd_adj[BW-2:0], bin[PW-1]};
    assign unused_top = bcd_adj[BW-1];

`ifdef IMUL_BCD_SIGNED_EN
    logic load_sign;
    logic sign_r;

    // Negating -2^(PW-1) wraps to itself, which read unsigned is the magnitude.
    assign load_sign = iProduct[PW-1];
    assign load_val  = load_sign ? -iProduct : iProduct;

    always_ff @(posedge Clock) begin
        if (accept) begin
            sign_r <= load_sign;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oSign <= 1'b0;
        end else if (state == SHIFT && last) begin
            oSign <= sign_r;
        end
    end
`else
    assign load_val = iProduct;
    assign oSign    = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            oBcd  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == SHIFT && last) begin
                oBcd <= bcd_nxt;
            end
        end
    end

    // Scratch registers are fully reloaded on accept, so they need no reset.
    always_ff @(posedge Clock) begin
        if (accept) begin
            bin <= load_val;
            bcd <= '0;
        end else if (state == SHIFT) begin
            bin <= {bin[PW-2:0], 1'b0};
            bcd <= bcd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        oReady    = 1'b0;
        oValid    = 1'b0;
        oBusy     = 1'b0;
        case (state)
            IDLE: begin
                oReady = 1'b1;
                if (iValid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                oBusy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (iReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/imul_product_bcd_converter.md
# imul_product_bcd_converter

Sequential binary-to-BCD converter placed directly downstream of the 4-bit integer multiplier. Accepts the 2*SIZE-bit product through a valid/ready handshake, converts it by iterative shift-and-add-3 (double dabble), one bit per clock. Presents DIGITS packed BCD digits to the display/readout stage through a second valid/ready handshake.

## Interface
- SIZE, 4, multiplier operand width; product width PW = 2*SIZE
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^PW - 1 (elaboration-time check)
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- iValid  in  1  product available from multiplier
- iProduct  in  PW  multiplier product
- oReady  out  1  converter can accept a product
- oValid  out  1  BCD result available
- iReady  in  1  downstream accepts result
- oBcd  out  4*DIGITS  packed BCD, digit 0 in bits [3:0]
- oSign  out  1  result sign (see Configuration)
- oBusy  out  1  conversion in progress

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: oReady=1. iValid=1 at a rising edge: capture iProduct into the shift register, clear the BCD scratch register, clear the bit counter, go SHIFT. iValid=0: stay.
- SHIFT: each cycle, every BCD digit >= 5 gets +3, then {bcd, bin} shifts left by 1. Counter increments. After the cycle with counter == PW-1, go DONE.
- DONE: oValid=1, oBcd held stable. iReady=1 at an edge: go IDLE. iReady=0: hold indefinitely.
- oReady is 1 only in IDLE. No new product is accepted in SHIFT or DONE. iValid during those states is ignored and the product is not consumed.
- oBusy=1 in SHIFT only.
- Counter width is clog2(PW). Digit add never overflows 4 bits, because a corrected digit is <= 12 before the shift.
- oBcd is a registered copy updated only on the SHIFT→DONE transition. It keeps its last value in IDLE/SHIFT, so readout does not flicker.

## Timing
- Reset asserted, including mid-conversion: state=IDLE, oReady=1, oValid=0, oBusy=0, oBcd=0, oSign=0, counter=0, immediately and asynchronously. Release is synchronous to the next edge.
- Latency: accepting edge E, then oValid rises after edge E+PW (8 cycles for SIZE=4).
- Result transfer at the edge where oValid&&iReady. oReady rises after that same edge. Next accept at the following edge earliest.
- Throughput: one product per PW+2 cycles when downstream never stalls.
- iValid held high continuously: a new product is accepted on each return to IDLE.

## Configuration
- IMUL_BCD_SIGNED_EN defined:
  - iProduct is two's complement.
  - On accept, the magnitude (negated if MSB=1) is loaded, and sign=MSB is registered.
  - oSign is updated with oBcd on the SHIFT→DONE transition.
  - Most negative input (-2^(PW-1)) converts to its magnitude 2^(PW-1).
  - Behaviour with PW = 8:
    - 0x80 → oBcd 0x128, oSign=1.
    - 0x00 → oSign=0.
- IMUL_BCD_SIGNED_EN not defined: iProduct unsigned, oSign constant 0, no negation logic.

## Structure
- Shared package `imul_pkg`:
  - FSM state encoding localparams (IDLE, SHIFT, DONE).
  - The DIGITS-sufficiency check function.
  - The default SIZE.
- One sub-module, `bcd_add3_digit`: 4-bit in, 4-bit out, adds 3 when the input is >= 5. Instantiated DIGITS times in a generate loop.
- Top level holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset, then iProduct=0xE1 (225), iValid one cycle, iReady=1 → oValid after 8 cycles, oBcd=0x225, oSign=0. oReady returns after the transfer edge.
- iProduct=0x00 → oBcd=0x000. iProduct=0x63 → oBcd=0x099. iProduct=0x0A → oBcd=0x010.
- iValid held high, stream 0x01, 0x09, 0x10 with iReady=1 → results 0x001, 0x009, 0x016, one every 10 cycles. No product lost or duplicated.
- Downstream stall: iReady=0 for 5 cycles after oValid, with iProduct changed and iValid asserted → oBcd stays constant, oReady=0, new product not taken until after the transfer.
- Reset asserted at the 4th SHIFT cycle of 0xE1 → all outputs 0 immediately, state IDLE. Next conversion 0x2D → oBcd=0x045 correct.
- IMUL_BCD_SIGNED_EN build: 0xF7 → oBcd=0x009, oSign=1. 0x80 → 0x128, oSign=1. 0x7F → 0x127, oSign=0.
